// File: rtl/cmlink_tx_framer.sv
// Camera Link base-config transmit framer: turns a valid/ready pixel stream into
// FVAL/LVAL/DVAL frame timing and packs each cycle into the 28-bit serializer word.
`timescale 1ns/1ps
module cmlink_tx_framer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 512,
  parameter int H_BLANK  = 64,
  parameter int V_FRONT  = 16,
  parameter int V_BACK   = 16,
  parameter int V_BLANK  = 32,
  parameter int CNT_W    = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [23:0] i_pix_data,
  input  logic        i_pix_valid,
  input  logic        i_pix_sof,
  output logic        o_pix_ready,
  output logic [27:0] o_cm_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_underflow
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VFP    = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBP    = 3'd4,
    ST_VBLANK = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] H_ACTIVE_M1 = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACTIVE_M1 = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_BLANK_M1  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_FRONT_M1  = CNT_W'(V_FRONT - 1);
  localparam logic [CNT_W-1:0] V_BACK_M1   = CNT_W'(V_BACK - 1);
  localparam logic [CNT_W-1:0] V_BLANK_M1  = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CNT_W-1:0]   x_r, x_s;
  logic [CNT_W-1:0]   y_r, y_s;
  logic               fval_s, lval_s, dval_s, ready_s, done_s, start_s;
  logic [27:0]        cm_data_r;
  logic               busy_r, done_r, underflow_r;

  // Scatter the three 8-bit ports and sync bits onto the serializer bit lanes.
  function automatic logic [27:0] pack_word(input logic fval, input logic lval,
                                            input logic dval, input logic [23:0] pix);
    logic [23:0] p;
    logic [27:0] w;
    p = dval ? pix : 24'd0;
    w = 28'd0;
    w[3]  = p[0];  w[7]  = p[1];  w[11] = p[2];  w[15] = p[3];
    w[19] = p[4];  w[23] = p[5];  w[0]  = p[6];  w[4]  = p[7];
    w[27] = p[8];  w[2]  = p[9];  w[6]  = p[10]; w[10] = p[11];
    w[14] = p[12]; w[18] = p[13]; w[8]  = p[14]; w[12] = p[15];
    w[22] = p[16]; w[26] = p[17]; w[1]  = p[18]; w[5]  = p[19];
    w[9]  = p[20]; w[13] = p[21]; w[16] = p[22]; w[20] = p[23];
    w[25] = dval;
    w[17] = lval;
    w[21] = fval;
    w[24] = 1'b0;
    return w;
  endfunction

  assign start_s = i_en & i_pix_valid & i_pix_sof;

  // Next-state, counters and per-cycle sync/ready decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    x_s     = x_r;
    y_s     = y_r;
    fval_s  = 1'b0;
    lval_s  = 1'b0;
    dval_s  = 1'b0;
    ready_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The SOF pixel is held back so it becomes the first DVAL beat.
        ready_s = ~(i_pix_valid & i_pix_sof);
        if (start_s) begin
          state_s = ST_VFP;
          cnt_s   = '0;
          x_s     = '0;
          y_s     = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_VFP: begin
        fval_s = 1'b1;
        if (cnt_r == V_FRONT_M1) begin
          state_s = ST_LINE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_LINE: begin
        fval_s  = 1'b1;
        lval_s  = 1'b1;
        ready_s = 1'b1;
        if (i_pix_valid) begin
          dval_s = 1'b1;
          if (x_r == H_ACTIVE_M1) begin
            x_s   = '0;
            cnt_s = '0;
            if (y_r < V_ACTIVE_M1) begin
              y_s     = y_r + CNT_ONE;
              state_s = ST_HBLANK;
            end else begin
              state_s = ST_VBP;
            end
          end else begin
            x_s = x_r + CNT_ONE;
          end
        end else begin
          x_s = x_r;
        end
      end
      ST_HBLANK: begin
        fval_s = 1'b1;
        if (cnt_r == H_BLANK_M1) begin
          state_s = ST_LINE;
          cnt_s   = '0;
          x_s     = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_VBP: begin
        fval_s = 1'b1;
        if (cnt_r == V_BACK_M1) begin
          state_s = ST_VBLANK;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_VBLANK: begin
        if (cnt_r == V_BLANK_M1) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        x_s     = '0;
        y_s     = '0;
      end
    endcase
  end

  // State and position counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      x_r     <= '0;
      y_r     <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      x_r     <= x_s;
      y_r     <= y_s;
    end
  end

  // Registered outputs, all aligned one cycle behind the producing state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cm_data_r   <= 28'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      cm_data_r <= pack_word(fval_s, lval_s, dval_s, i_pix_data);
      busy_r    <= (state_r != ST_IDLE);
      done_r    <= done_s;
      if ((state_r == ST_IDLE) && start_s) begin
        underflow_r <= 1'b0;
      end else if ((state_r == ST_LINE) && !i_pix_valid) begin
        underflow_r <= 1'b1;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign o_pix_ready  = ready_s;
  assign o_cm_data    = cm_data_r;
  assign o_busy       = busy_r;
  assign o_frame_done = done_r;
  assign o_underflow  = underflow_r;

endmodule

// File: tb/tb_cmlink_tx_framer.sv
// Directed bench for cmlink_tx_framer with a small frame geometry
// (4x2 active, H_BLANK=2, V_FRONT=3, V_BACK=2, V_BLANK=4).
`timescale 1ns/1ps
module tb_cmlink_tx_framer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [27:0] cm_data;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Per-frame observations filled by run_frame.
  int          n_fval, n_low, n_dval, n_gap, n_done;
  logic [31:0] lval_seq;
  logic [27:0] w_vfp;
  logic [27:0] words [8];
  logic        uf_start;
  logic        timed_out;
  logic        found;

  cmlink_tx_framer #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2),
    .V_FRONT(3), .V_BACK(2), .V_BLANK(4), .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_en(en),
    .i_pix_data(pix_data),
    .i_pix_valid(pix_valid),
    .i_pix_sof(pix_sof),
    .o_pix_ready(pix_ready),
    .o_cm_data(cm_data),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int i);
    case (i)
      0:       return 24'h000001;
      1:       return 24'h000100;
      2:       return 24'h010000;
      7:       return 24'hFFFFFF;
      default: return 24'h5A5A5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed one 8-pixel frame, optionally withholding valid mid-line or dropping
  // i_en once the first line is done, and record what appears on o_cm_data.
  task automatic run_frame(input int drop_at, input int drop_n, input bit en_off);
    int  idx;
    int  dropped;
    bit  acc;
    bit  seen_f;
    logic [27:0] w;
    idx = 0; dropped = 0; seen_f = 1'b0;
    n_fval = 0; n_low = 0; n_dval = 0; n_gap = 0; n_done = 0;
    lval_seq = 32'd0; w_vfp = 28'd0; uf_start = 1'bx; timed_out = 1'b1;
    for (int k = 0; k < 8; k++) words[k] = 28'd0;
    en = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = pix(0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = pix_valid & pix_ready;
      w = cm_data;
      if (w[21]) begin
        if (!seen_f) begin
          w_vfp    = w;
          uf_start = underflow;
        end
        seen_f = 1'b1;
        n_fval++;
        lval_seq = {lval_seq[30:0], w[17]};
        if (w[17] && !w[25]) n_gap++;
      end else if (seen_f) begin
        n_low++;
      end
      if (w[25]) begin
        if (n_dval < 8) words[n_dval] = w;
        n_dval++;
      end
      if (frame_done) begin
        n_done++;
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (en_off && idx >= 4) en = 1'b0;
      if (idx >= 8) begin
        pix_valid = en_off; pix_sof = en_off; pix_data = 24'd0;
      end else if (idx == drop_at && dropped < drop_n) begin
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 24'd0;
        dropped++;
      end else begin
        pix_valid = 1'b1; pix_sof = (idx == 0); pix_data = pix(idx);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; pix_data = 24'd0; pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cm_data", 32'(cm_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_underflow", 32'(underflow), 32'h0);
    check("rst_ready", 32'(pix_ready), 32'h1);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Frame timing and packing with continuous valid
    run_frame(-1, 0, 1'b0);
    check("t1_timeout", 32'(timed_out), 32'h0);
    check("t1_fval_cycles", n_fval, 15);
    check("t1_lval_pattern", lval_seq, 32'b000111100111100);
    check("t1_dval_beats", n_dval, 8);
    check("t1_fval_low", n_low, 4);
    check("t1_vfp_word", 32'(w_vfp), 32'h0020_0000);
    check("t2_pix_a", 32'(words[0]), 32'h0222_0008);
    check("t2_pix_b", 32'(words[1]), 32'h0A22_0000);
    check("t2_pix_c", 32'(words[2]), 32'h0262_0000);
    check("t2_pix_ff", 32'(words[7]), 32'h0EFF_FFFF);
    check("t1_underflow", 32'(underflow), 32'h0);
    @(negedge clk);
    check("t1_done_single", 32'(frame_done), 32'h0);
    check("t1_busy_after", 32'(busy), 32'h0);

    // Two missing pixels mid-line
    @(posedge clk); #1;
    run_frame(2, 2, 1'b0);
    check("t3_timeout", 32'(timed_out), 32'h0);
    check("t3_uf_at_start", 32'(uf_start), 32'h0);
    check("t3_fval_cycles", n_fval, 17);
    check("t3_lval_pattern", lval_seq, 32'b00011111100111100);
    check("t3_gap_cycles", n_gap, 2);
    check("t3_dval_beats", n_dval, 8);
    check("t3_pix_ff", 32'(words[7]), 32'h0EFF_FFFF);
    check("t3_underflow_sticky", 32'(underflow), 32'h1);

    // Non-SOF pixels in IDLE are dropped; SOF waits for i_en
    @(posedge clk); #1;
    en = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 24'hFFFFFF;
    @(negedge clk);
    check("t4_ready_nonsof", 32'(pix_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t4_cm_idle", 32'(cm_data), 32'h0);
    check("t4_busy_idle", 32'(busy), 32'h0);
    @(posedge clk); #1;
    en = 1'b0; pix_sof = 1'b1;
    @(negedge clk);
    check("t4_ready_sof_en0", 32'(pix_ready), 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_busy_en0", 32'(busy), 32'h0);
    check("t4_cm_en0", 32'(cm_data), 32'h0);
    check("t4_uf_held", 32'(underflow), 32'h1);
    @(posedge clk); #1;
    run_frame(-1, 0, 1'b0);
    check("t4_timeout", 32'(timed_out), 32'h0);
    check("t3_uf_cleared", 32'(uf_start), 32'h0);
    check("t4_fval_cycles", n_fval, 15);

    // Asynchronous reset while in LINE
    @(posedge clk); #1;
    en = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 24'h00AA55;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cm_data[17]) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_line", 32'(found), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_cm_in_reset", 32'(cm_data), 32'h0);
    check("t5_busy_in_reset", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1; pix_sof = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_no_start_nonsof", 32'(busy), 32'h0);
    check("t5_cm_idle", 32'(cm_data), 32'h0);
    @(posedge clk); #1;
    run_frame(-1, 0, 1'b0);
    check("t5_timeout", 32'(timed_out), 32'h0);
    check("t5_fval_cycles", n_fval, 15);
    check("t5_dval_beats", n_dval, 8);

    // i_en dropped during HBLANK with SOF offered afterwards
    @(posedge clk); #1;
    run_frame(-1, 0, 1'b1);
    check("t6_timeout", 32'(timed_out), 32'h0);
    check("t6_fval_cycles", n_fval, 15);
    check("t6_dval_beats", n_dval, 8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_no_restart_busy", 32'(busy), 32'h0);
    check("t6_ready_held", 32'(pix_ready), 32'h0);
    check("t6_cm_idle", 32'(cm_data), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
